// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pattern generator:
//   - default 640x480@60 timing constants (pixel clocks / lines)
//   - pattern mode encoding
//   - colour-bar table ({R,G,B} lit flags, bar 0 = leftmost)
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    typedef enum logic [1:0] {
        GRADIENT = 2'd0,
        BARS     = 2'd1,
        CHECKER  = 2'd2,
        SOLID    = 2'd3
    } mode_e;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000,  // 7 black
        3'b001,  // 6 blue
        3'b100,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b011,  // 2 cyan
        3'b110,  // 1 yellow
        3'b111   // 0 white
    };

endpackage

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Raster position counters and combinational sync/active decode.
//   clk_i         : pixel clock
//   rst_i         : asynchronous active-high reset (counters to 0,0)
//   x_o, y_o      : current raster position
//   hsync_win_o   : x inside the horizontal sync window
//   vsync_win_o   : y inside the vertical sync window
//   active_o      : position is in the visible area
//   frame_first_o : position is (0,0)
//   frame_last_o  : position is (H_TOTAL-1, V_TOTAL-1)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned X_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int unsigned Y_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           hsync_win_o,
    output logic           vsync_win_o,
    output logic           active_o,
    output logic           frame_first_o,
    output logic           frame_last_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [X_W-1:0] X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] X_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0] VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign hsync_win_o   = (x_q >= HS_START) && (x_q <= HS_END);
    assign vsync_win_o   = (y_q >= VS_START) && (y_q <= VS_END);
    assign active_o      = (x_q < X_ACT) && (y_q < Y_ACT);
    assign frame_first_o = (x_q == '0) && (y_q == '0);
    assign frame_last_o  = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/vga_pattern_gen.sv
// ----------------------------------------------------------------------------
// vga_pattern_gen
// VGA test-pattern source: gradient, colour bars, checkerboard, solid white.
//   clk          : pixel clock
//   reset        : asynchronous active-high reset
//   mode_sel     : requested pattern, adopted only at the frame boundary
//   hsync, vsync : sync outputs, asserted level = SYNC_POL
//   red/green/blue : pixel colour, COLOR_W bits each, 0 outside active area
//   active_video : pixel is visible
//   frame_start  : one-cycle pulse with output pixel (0,0)
// All outputs are registered and lag the raster counters by one cycle.
// Optional macro VGA_PATTERN_SCROLL_EN: gradient and checker patterns scroll
// horizontally by one pixel per frame (x' = x + frame count).
// ----------------------------------------------------------------------------
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W     = 3,
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_FP        = H_FP_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_FP        = V_FP_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned CHECK_SHIFT = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode_sel,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               active_video,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned X_W     = $clog2(H_TOTAL);
    localparam int unsigned Y_W     = $clog2(V_TOTAL);

    localparam logic [X_W-1:0] BAR_WIDTH = X_W'(H_ACTIVE / 8);

    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           hs_win, vs_win, act, frm_first, frm_last;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_timing (
        .clk_i         (clk),
        .rst_i         (reset),
        .x_o           (x_cnt),
        .y_o           (y_cnt),
        .hsync_win_o   (hs_win),
        .vsync_win_o   (vs_win),
        .active_o      (act),
        .frame_first_o (frm_first),
        .frame_last_o  (frm_last)
    );

    mode_e mode_q, mode_d;

    // Latched on the last counter position so the new mode lands exactly on pixel (0,0).
    always_comb begin
        mode_d = mode_q;
        if (frm_last) begin
            mode_d = mode_e'(mode_sel);
        end
    end

    logic [X_W-1:0] x_pat;

`ifdef VGA_PATTERN_SCROLL_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Advances together with the frame wrap, so frame N after reset sees count N.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frm_last) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Sum truncates to X_W bits, giving the modulo-2^X_W wrap.
    assign x_pat = x_cnt + X_W'(frame_cnt_q);
`else
    assign x_pat = x_cnt;
`endif

    logic [31:0]        xy_mix;
    logic [X_W-1:0]     bar_full;
    logic [2:0]         bar_idx;
    logic [2:0]         bar_col;
    logic               chk_on;
    logic [COLOR_W-1:0] red_d, green_d, blue_d;

    always_comb begin
        red_d    = '0;
        green_d  = '0;
        blue_d   = '0;
        xy_mix   = 32'(x_pat) ^ 32'(y_cnt);
        chk_on   = 1'(xy_mix >> CHECK_SHIFT);
        bar_full = x_cnt / BAR_WIDTH;
        bar_idx  = (bar_full > X_W'(7)) ? 3'd7 : bar_full[2:0];
        bar_col  = BAR_RGB[bar_idx];

        unique case (mode_q)
            GRADIENT: begin
                red_d   = COLOR_W'(x_pat >> (X_W - COLOR_W));
                green_d = COLOR_W'(y_cnt >> (Y_W - COLOR_W));
                for (int unsigned i = 0; i < COLOR_W; i++) begin
                    blue_d[i] = 1'(xy_mix >> (CHECK_SHIFT + i));
                end
            end
            BARS: begin
                red_d   = {COLOR_W{bar_col[2]}};
                green_d = {COLOR_W{bar_col[1]}};
                blue_d  = {COLOR_W{bar_col[0]}};
            end
            CHECKER: begin
                red_d   = {COLOR_W{chk_on}};
                green_d = {COLOR_W{chk_on}};
                blue_d  = {COLOR_W{chk_on}};
            end
            SOLID: begin
                red_d   = '1;
                green_d = '1;
                blue_d  = '1;
            end
        endcase

        if (!act) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end
    end

    logic               hsync_q, vsync_q, active_q, fstart_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q   <= GRADIENT;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            active_q <= 1'b0;
            fstart_q <= 1'b0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            mode_q   <= mode_d;
            hsync_q  <= hs_win ? SYNC_POL : ~SYNC_POL;
            vsync_q  <= vs_win ? SYNC_POL : ~SYNC_POL;
            active_q <= act;
            fstart_q <= frm_first;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign active_video = active_q;
    assign frame_start  = fstart_q;
    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_pattern_gen
// Three instances share clock and reset:
//   A: small raster (80x32), SYNC_POL=1, CHECK_SHIFT=2 -- mode changes
//   B: default horizontal timing, short frame (16 lines), COLOR_W=3
//   C: as B with COLOR_W=4
// Every output cycle of every instance is compared against a position-based
// reference model; named checks cover specific pixels and sync timing.
// ----------------------------------------------------------------------------
module tb_vga_pattern_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int cw; int cs; int pol;
    } cfg_t;

    localparam cfg_t CA = '{64, 4, 8, 4, 24, 2, 2, 4, 3, 2, 1};
    localparam cfg_t CB = '{640, 16, 96, 48, 12, 1, 1, 2, 3, 5, 0};
    localparam cfg_t CC = '{640, 16, 96, 48, 12, 1, 1, 2, 4, 5, 0};

    localparam int FT_A   = 80 * 32;
    localparam int FT_B   = 800 * 16;
    localparam int RST_AT = 40000;
    localparam int NCYC   = 54000;

`ifdef VGA_PATTERN_SCROLL_EN
    localparam int SCROLL = 1;
`else
    localparam int SCROLL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode_sel_a, mode_sel_b;

    logic       hsync_a, vsync_a, av_a, fs_a;
    logic [2:0] red_a, green_a, blue_a;
    logic       hsync_b, vsync_b, av_b, fs_b;
    logic [2:0] red_b, green_b, blue_b;
    logic       hsync_c, vsync_c, av_c, fs_c;
    logic [3:0] red_c, green_c, blue_c;

    always #5 clk = ~clk;

    vga_pattern_gen #(
        .COLOR_W(CA.cw), .H_ACTIVE(CA.ha), .H_FP(CA.hf), .H_SYNC(CA.hs), .H_BP(CA.hb),
        .V_ACTIVE(CA.va), .V_FP(CA.vf), .V_SYNC(CA.vs), .V_BP(CA.vb),
        .SYNC_POL(1'(CA.pol)), .CHECK_SHIFT(CA.cs)
    ) dut_a (
        .clk(clk), .reset(reset), .mode_sel(mode_sel_a),
        .hsync(hsync_a), .vsync(vsync_a), .red(red_a), .green(green_a), .blue(blue_a),
        .active_video(av_a), .frame_start(fs_a)
    );

    vga_pattern_gen #(
        .COLOR_W(CB.cw), .H_ACTIVE(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hs), .H_BP(CB.hb),
        .V_ACTIVE(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb),
        .SYNC_POL(1'(CB.pol)), .CHECK_SHIFT(CB.cs)
    ) dut_b (
        .clk(clk), .reset(reset), .mode_sel(mode_sel_b),
        .hsync(hsync_b), .vsync(vsync_b), .red(red_b), .green(green_b), .blue(blue_b),
        .active_video(av_b), .frame_start(fs_b)
    );

    vga_pattern_gen #(
        .COLOR_W(CC.cw), .H_ACTIVE(CC.ha), .H_FP(CC.hf), .H_SYNC(CC.hs), .H_BP(CC.hb),
        .V_ACTIVE(CC.va), .V_FP(CC.vf), .V_SYNC(CC.vs), .V_BP(CC.vb),
        .SYNC_POL(1'(CC.pol)), .CHECK_SHIFT(CC.cs)
    ) dut_c (
        .clk(clk), .reset(reset), .mode_sel(mode_sel_b),
        .hsync(hsync_c), .vsync(vsync_c), .red(red_c), .green(green_c), .blue(blue_c),
        .active_video(av_c), .frame_start(fs_c)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   k;
    int   pend [3];
    int   fmode [3];
    cfg_t cfgs [3];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    function automatic int frame_len(input cfg_t c);
        return (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
    endfunction

    // Expected {hsync, vsync, active, frame_start, r[7:0], g[7:0], b[7:0]} for
    // the k-th output cycle after reset release (k >= 1).
    function automatic int model_px(input cfg_t c, input int mode, input int kk);
        int ht, vt, ft, p, x, y, fcnt, xw, yw, xs, lit, r, g, b, bar, rgb;
        bit hs_on, vs_on, av, fs, hl, vl;
        logic [23:0] tbl;
        tbl   = {3'd0, 3'd1, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6, 3'd7};
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        ft    = ht * vt;
        p     = (kk - 1) % ft;
        x     = p % ht;
        y     = p / ht;
        fcnt  = ((kk - 1) / ft) % 256;
        xw    = $clog2(ht);
        yw    = $clog2(vt);
        lit   = (1 << c.cw) - 1;
        hs_on = (x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs);
        vs_on = (y >= c.va + c.vf) && (y < c.va + c.vf + c.vs);
        av    = (x < c.ha) && (y < c.va);
        fs    = (p == 0);
        hl    = hs_on ? c.pol[0] : !c.pol[0];
        vl    = vs_on ? c.pol[0] : !c.pol[0];
        xs    = x;
        if (SCROLL != 0 && (mode == 0 || mode == 2)) xs = (x + fcnt) % (1 << xw);
        r = 0; g = 0; b = 0;
        case (mode)
            0: begin
                r = xs / (1 << (xw - c.cw));
                g = y / (1 << (yw - c.cw));
                for (int i = 0; i < c.cw; i++)
                    b += (((xs >> (c.cs + i)) ^ (y >> (c.cs + i))) & 1) << i;
            end
            1: begin
                bar = x / (c.ha / 8);
                if (bar > 7) bar = 7;
                rgb = int'((tbl >> (3 * bar)) & 24'd7);
                r = (rgb & 4) != 0 ? lit : 0;
                g = (rgb & 2) != 0 ? lit : 0;
                b = (rgb & 1) != 0 ? lit : 0;
            end
            2: begin
                r = (((xs >> c.cs) ^ (y >> c.cs)) & 1) != 0 ? lit : 0;
                g = r;
                b = r;
            end
            default: begin
                r = lit; g = lit; b = lit;
            end
        endcase
        if (!av) begin
            r = 0; g = 0; b = 0;
        end
        return {4'd0, hl, vl, av, fs, r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic int rst_exp(input cfg_t c);
        return {4'd0, !c.pol[0], !c.pol[0], 26'd0};
    endfunction

    function automatic int obs_of(input int d);
        case (d)
            0:       return {4'd0, hsync_a, vsync_a, av_a, fs_a, 8'(red_a), 8'(green_a), 8'(blue_a)};
            1:       return {4'd0, hsync_b, vsync_b, av_b, fs_b, 8'(red_b), 8'(green_b), 8'(blue_b)};
            default: return {4'd0, hsync_c, vsync_c, av_c, fs_c, 8'(red_c), 8'(green_c), 8'(blue_c)};
        endcase
    endfunction

    task automatic check_rst(input string tag);
        for (int d = 0; d < 3; d++)
            chk($sformatf("%s_%0d", tag, d), obs_of(d), rst_exp(cfgs[d]));
    endtask

    task automatic check_cycle();
        for (int d = 0; d < 3; d++) begin
            if ((k - 1) % frame_len(cfgs[d]) == 0) fmode[d] = pend[d];
            chk($sformatf("px_%0d", d), obs_of(d), model_px(cfgs[d], fmode[d], k));
        end
    endtask

    task automatic record_modes();
        for (int d = 0; d < 3; d++)
            if (k % frame_len(cfgs[d]) == frame_len(cfgs[d]) - 1)
                pend[d] = (d == 0) ? int'(mode_sel_a) : int'(mode_sel_b);
    endtask

    initial begin
        bit seg0;
        bit prev_hs;
        int n_hs, k_hs0, fs_cnt_a, k_fs_a0, fs_cnt_b, k_fs_b0;
        cfgs[0] = CA; cfgs[1] = CB; cfgs[2] = CC;
        for (int d = 0; d < 3; d++) begin
            pend[d]  = 0;
            fmode[d] = 0;
        end
        seg0 = 1; prev_hs = 0; n_hs = 0; k_hs0 = 0;
        fs_cnt_a = 0; k_fs_a0 = 0; fs_cnt_b = 0; k_fs_b0 = 0;
        k = 0;
        reset = 1'b1;
        mode_sel_a = 2'd0;
        mode_sel_b = 2'd0;
        repeat (3) @(negedge clk);
        check_rst("rst_init");
        reset = 1'b0;

        for (int t = 1; t <= NCYC; t++) begin
            @(negedge clk);
            if (t == RST_AT) begin
                chk("fs_count_a", fs_cnt_a, (k - 1) / FT_A + 1);
                #2 reset = 1'b1;
                #1 check_rst("rst_async");
                repeat (2) @(negedge clk);
                check_rst("rst_hold");
                reset = 1'b0;
                k = 0;
                seg0 = 0;
                for (int d = 0; d < 3; d++) begin
                    pend[d]  = 0;
                    fmode[d] = 0;
                end
                continue;
            end
            k++;
            check_cycle();

            if (seg0) begin
                // horizontal sync timing on B (active-low)
                if (!hsync_b && !prev_hs) begin
                    if (n_hs == 0) begin
                        chk("hs_start_x", (k - 1) % 800, 656);
                        k_hs0 = k;
                    end else if (n_hs == 1) begin
                        chk("line_period", k - k_hs0, 800);
                    end
                    n_hs++;
                end
                if (hsync_b && prev_hs && n_hs == 1) chk("hs_width", k - k_hs0, 96);
                prev_hs = !hsync_b;

                if (fs_a) begin
                    if (fs_cnt_a == 0) k_fs_a0 = k;
                    else if (fs_cnt_a == 1) chk("frame_period_a", k - k_fs_a0, 2560);
                    fs_cnt_a++;
                end
                if (fs_b) begin
                    if (fs_cnt_b == 0) k_fs_b0 = k;
                    else if (fs_cnt_b == 1) chk("frame_period_b", k - k_fs_b0, 12800);
                    fs_cnt_b++;
                end

                case (k)
                    640: begin
                        chk("red_639_cw3", int'(red_b), 4);
                        chk("red_639_cw4", int'(red_c), 9);
                    end
                    965:   chk("grad_after_chg", int'({red_a, green_a, blue_a}), 'h01A);
                    2565:  chk("ckr_next_frame", int'({red_a, green_a, blue_a}), 'h1FF);
                    12801: chk("bar_x0", int'({red_b, green_b, blue_b}), 'h1FF);
                    12881: chk("bar_x80", int'({red_b, green_b, blue_b}), 'h1F8);
                    13440: chk("bar_x639", int'({red_b, green_b, blue_b}), 0);
                    13441: begin
                        chk("bar_x640_rgb", int'({red_b, green_b, blue_b}), 0);
                        chk("bar_x640_av", int'(av_b), 0);
                    end
                    38526: chk("scroll_x125", int'(red_b), SCROLL);
                    default: ;
                endcase

                if (k == 100)   mode_sel_b = 2'd1;
                if (k == 805)   mode_sel_a = 2'd2;
                if (k == 13800) mode_sel_b = 2'd0;
                if (k >= 5121 && k % 700 == 0) mode_sel_a = 2'($urandom_range(0, 3));
            end else begin
                if (k == 1) chk("fs_after_rst", int'(fs_b), 1);
                if (k % 500 == 0)  mode_sel_a = 2'($urandom_range(0, 3));
                if (k % 4000 == 0) mode_sel_b = 2'($urandom_range(0, 3));
            end

            record_modes();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter COLOR_W, default 3: bits per colour channel (1..8).
REQ-002 SHALL have parameters H_ACTIVE, H_FP, H_SYNC, H_BP with defaults 640, 16, 96, 48: horizontal timing in pixel clocks.
REQ-003 SHALL have parameters V_ACTIVE, V_FP, V_SYNC, V_BP with defaults 480, 10, 2, 33: vertical timing in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0: asserted sync level (0 = active-low).
REQ-005 SHALL have parameter CHECK_SHIFT, default 5: checker square edge is 2^CHECK_SHIFT pixels.
REQ-006 SHALL have port clk, input, 1: pixel clock (25 MHz at the default timing).
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port mode_sel, input, 2: requested pattern.
REQ-009 SHALL have port hsync, output, 1: horizontal sync.
REQ-010 SHALL have port vsync, output, 1: vertical sync.
REQ-011 SHALL have ports red, green, blue, output, COLOR_W each: pixel colour.
REQ-012 SHALL have port active_video, output, 1: pixel is visible.
REQ-013 SHALL have port frame_start, output, 1: one-cycle pulse coincident with output pixel (0,0).

Function
REQ-014 SHALL count x over 0..H_TOTAL-1 and y over 0..V_TOTAL-1 (H_TOTAL, V_TOTAL = sums of the four timing parameters); x wraps to 0 and y increments on x = H_TOTAL-1; y wraps to 0 at (H_TOTAL-1, V_TOTAL-1).
REQ-015 SHALL assert hsync for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], and vsync likewise for y; active when x<H_ACTIVE and y<V_ACTIVE.
REQ-016 SHALL register every output, so all outputs lag the counters by exactly 1 cycle and stay mutually aligned.
REQ-017 SHALL latch mode_sel into mode_q only at counter (H_TOTAL-1, V_TOTAL-1); a mode change SHALL take effect at the next frame_start and never mid-frame.
REQ-018 SHALL, in mode 0 (gradient), output red = x >> (X_W-COLOR_W) and green = y >> (Y_W-COLOR_W); blue bit i = x[CHECK_SHIFT+i] XOR y[CHECK_SHIFT+i]. X_W and Y_W are $clog2(H_TOTAL) and $clog2(V_TOTAL).
REQ-019 SHALL, in mode 1, output 8 bars each H_ACTIVE/8 wide, left to right: white, yellow, cyan, green, magenta, red, blue, black; a lit channel is all ones.
REQ-020 SHALL, in mode 2, output all-ones on all channels where x[CHECK_SHIFT] XOR y[CHECK_SHIFT] = 1, else zero.
REQ-021 SHALL, in mode 3, output solid white.
REQ-022 SHALL drive red/green/blue to 0 whenever active_video is 0, in every mode.
REQ-023 SHALL keep an 8-bit frame counter that increments at each frame_start and wraps from 255 to 0.

Reset
REQ-024 SHALL, while reset is high: clear x, y, mode_q and frame counter to 0; drive red/green/blue, active_video and frame_start to 0; hold hsync and vsync at the deasserted level (~SYNC_POL).
REQ-025 SHALL, on reset assertion mid-frame, apply REQ-024 immediately, with no clock edge required.
REQ-026 SHALL, after reset release, restart from counter (0,0) with mode 0; the first frame_start SHALL occur on the first output cycle.

Configuration
REQ-027 SHALL, when VGA_PATTERN_SCROLL_EN is defined, use x' = (x + frame counter) mod 2^X_W in place of x for modes 0 and 2 only.
REQ-028 SHALL, when VGA_PATTERN_SCROLL_EN is undefined, use x unmodified in all modes; the frame counter MAY then be optimised away, but frame_start SHALL remain.

Structure
REQ-029 SHALL take from shared package vga_pkg: default timing constants, the mode encoding (GRADIENT=0, BARS=1, CHECKER=2, SOLID=3), and the bar colour table.
REQ-030 SHALL place the counters and sync/active decode in sub-module vga_timing_gen, parametrised by the timing parameters; pattern logic and output registers remain in vga_pattern_gen.

Verification
REQ-031 SHALL verify, with default parameters and reset released: line period 800 cycles; hsync low for exactly 96 cycles starting 656 cycles after each line start; frame period 420000 cycles; one frame_start per frame.
REQ-032 SHALL verify mode_sel=1, after the next frame_start: x=0 outputs white 7/7/7; x=80 outputs yellow 7/7/0; x=639 outputs black 0/0/0; x=640 outputs 0 with active_video=0.
REQ-033 SHALL verify that changing mode_sel from 0 to 2 at line 100: the remaining lines of that frame stay gradient, and checker starts at the next frame_start.
REQ-034 SHALL verify COLOR_W=4, mode 0: pixel (639,0) outputs red = 9; with COLOR_W=3 the same pixel outputs red = 4.
REQ-035 SHALL verify reset asserted mid-line 200: all outputs reach reset values before the next clock edge; after release, frame_start occurs on the first output cycle.
REQ-036 SHALL verify, with VGA_PATTERN_SCROLL_EN defined, mode 0, fourth frame after reset (counter = 3): pixel x=125 outputs red = 1; without the macro the same pixel outputs red = 0.
